// File: rtl/frame_line_reader.sv
// -----------------------------------------------------------------------------
// frame_line_reader
//
// Pulls words from the head of a show-ahead FIFO and emits them as one frame of
// V_LINES lines x H_WORDS words, tagging the first word of the frame (sof) and
// the last word of every line (eol). A single output register sits between the
// FIFO and the frame sink, so throughput is one word per cycle when both sides
// are ready. FIFO underrun cycles are counted in stall_cnt.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; nothing is popped
//   RUN   | popping words into the output register, counting h/v position
//   FLUSH | last word popped; waiting for the output register to drain
//   DONE  | one-cycle frame-complete pulse, then back to IDLE
//
// Ports:
//   rd_clk     in   sole clock, rising edge
//   rd_rst     in   synchronous active-high reset
//   start      in   frame start request (accepted in IDLE only)
//   abort      in   abandon current frame (wins over start)
//   rd_data    in   FIFO head word
//   rd_vld     in   FIFO head word valid
//   rd_en      out  pop FIFO head (combinational)
//   frm_data   out  frame word
//   frm_vld    out  frame word valid
//   frm_rdy    in   sink accepts frame word
//   frm_sof    out  first word of frame
//   frm_eol    out  last word of line
//   busy       out  frame in progress (RUN or FLUSH)
//   done       out  one-cycle frame-complete pulse
//   stall_cnt  out  saturating count of RUN cycles lost to FIFO underrun
// -----------------------------------------------------------------------------
module frame_line_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int H_WORDS    = 640,
  parameter int V_LINES    = 480
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_vld,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] frm_data,
  output logic                  frm_vld,
  input  logic                  frm_rdy,
  output logic                  frm_sof,
  output logic                  frm_eol,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] H_LAST = 16'(H_WORDS - 1);
  localparam logic [15:0] V_LAST = 16'(V_LINES - 1);

  state_t                state_q,     state_d;
  logic [DATA_WIDTH-1:0] frm_data_q,  frm_data_d;
  logic                  frm_vld_q,   frm_vld_d;
  logic                  frm_sof_q,   frm_sof_d;
  logic                  frm_eol_q,   frm_eol_d;
  logic [15:0]           h_cnt_q,     h_cnt_d;
  logic [15:0]           v_cnt_q,     v_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;

  logic out_free;
  logic xfer;
  logic pop;
  logic line_end;
  logic frame_end;

  // The output register can take a new word when it is empty or is being
  // drained this very cycle. Abort and reset block the pop so that the
  // FIFO never loses a word to a frame that is being thrown away.
  assign out_free  = ~frm_vld_q | frm_rdy;
  assign xfer      = frm_vld_q & frm_rdy;
  assign pop       = rd_vld & (state_q == ST_RUN) & out_free & ~abort & ~rd_rst;
  assign line_end  = (h_cnt_q == H_LAST);
  assign frame_end = line_end & (v_cnt_q == V_LAST);

  always_comb begin
    state_d     = state_q;
    frm_data_d  = frm_data_q;
    frm_vld_d   = frm_vld_q;
    frm_sof_d   = frm_sof_q;
    frm_eol_d   = frm_eol_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    stall_cnt_d = stall_cnt_q;

    // Output register: load on pop, empty on a transfer with no refill,
    // otherwise hold (covers frm_rdy=0 backpressure).
    if (pop) begin
      frm_data_d = rd_data;
      frm_vld_d  = 1'b1;
      frm_sof_d  = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
      frm_eol_d  = line_end;
    end else if (xfer) begin
      frm_vld_d  = 1'b0;
      frm_sof_d  = 1'b0;
      frm_eol_d  = 1'b0;
    end

    // Raster position of the next word to be popped.
    if (pop) begin
      if (line_end) begin
        h_cnt_d = 16'd0;
        v_cnt_d = frame_end ? 16'd0 : v_cnt_q + 16'd1;
      end else begin
        h_cnt_d = h_cnt_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          stall_cnt_d = 16'd0;
        end
      end
      ST_RUN: begin
        // Underrun: the sink could have taken a word but the FIFO had none.
        if (~rd_vld && out_free && (stall_cnt_q != 16'hFFFF)) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (pop && frame_end) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (~frm_vld_q || xfer) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort throws the frame away from any state; the stall count is kept so
    // the cause of an aborted frame can still be inspected afterwards.
    if (abort) begin
      state_d     = ST_IDLE;
      frm_vld_d   = 1'b0;
      frm_sof_d   = 1'b0;
      frm_eol_d   = 1'b0;
      h_cnt_d     = 16'd0;
      v_cnt_d     = 16'd0;
      stall_cnt_d = stall_cnt_q;
    end

    // Status flags are registered copies of the next state so that they line
    // up exactly with the state they describe.
    busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q     <= ST_IDLE;
      frm_data_q  <= '0;
      frm_vld_q   <= 1'b0;
      frm_sof_q   <= 1'b0;
      frm_eol_q   <= 1'b0;
      h_cnt_q     <= 16'd0;
      v_cnt_q     <= 16'd0;
      stall_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frm_data_q  <= frm_data_d;
      frm_vld_q   <= frm_vld_d;
      frm_sof_q   <= frm_sof_d;
      frm_eol_q   <= frm_eol_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en     = pop;
  assign frm_data  = frm_data_q;
  assign frm_vld   = frm_vld_q;
  assign frm_sof   = frm_sof_q;
  assign frm_eol   = frm_eol_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_frame_line_reader.sv
// -----------------------------------------------------------------------------
// tb_frame_line_reader
//
// Bench for frame_line_reader with H_WORDS=4, V_LINES=2. The bench plays the
// FIFO (rd_data is the next word of a sequence) and keeps a reference model
// that tracks the frame as "words popped so far" plus a one-word output slot;
// sof/eol come from the word's index within the frame.
// -----------------------------------------------------------------------------
module tb_frame_line_reader;

  localparam int DW = 32;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NW = H * V;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [DW-1:0] rd_data;
  logic          rd_vld, rd_en;
  logic [DW-1:0] frm_data;
  logic          frm_vld, frm_rdy, frm_sof, frm_eol;
  logic          busy, done;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  frame_line_reader #(.DATA_WIDTH(DW), .H_WORDS(H), .V_LINES(V)) dut (
    .rd_clk   (clk),
    .rd_rst   (rst),
    .start    (start),
    .abort    (abort),
    .rd_data  (rd_data),
    .rd_vld   (rd_vld),
    .rd_en    (rd_en),
    .frm_data (frm_data),
    .frm_vld  (frm_vld),
    .frm_rdy  (frm_rdy),
    .frm_sof  (frm_sof),
    .frm_eol  (frm_eol),
    .busy     (busy),
    .done     (done),
    .stall_cnt(stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 run, 2 flush, 3 done.
  int          m_phase;
  int          m_idx;
  bit          m_v, m_sof, m_eol;
  logic [31:0] m_data;
  int          m_stall;
  int          m_done_cnt, dut_done_cnt, xfer_cnt;
  logic [31:0] src_next;
  bit          seq_data;

  assign rd_data = src_next;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_v = 0; m_sof = 0; m_eol = 0;
    m_data = '0; m_stall = 0;
  endtask

  // One clock: check rd_en against the model, advance DUT and model, then
  // compare registered outputs at the falling edge.
  task automatic step();
    bit pop, xfer;
    #1;
    xfer = m_v && frm_rdy;
    pop  = !rst && !abort && (m_phase == 1) && rd_vld && (!m_v || frm_rdy);
    check_eq("rd_en", rd_en, pop);
    check_eq("rd_en_without_vld", rd_en & ~rd_vld, 1'b0);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (abort) begin
      m_phase = 0; m_idx = 0; m_v = 0; m_sof = 0; m_eol = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_stall = 0; end
        1: if (!rd_vld && (!m_v || frm_rdy) && m_stall < 65535) m_stall++;
        2: if (!m_v || xfer) m_phase = 3;
        3: m_phase = 0;
        default: m_phase = 0;
      endcase
      if (xfer) xfer_cnt++;
      if (pop) begin
        m_data = src_next;
        m_sof  = (m_idx == 0);
        m_eol  = (m_idx % H) == H - 1;
        m_v    = 1;
        m_idx++;
        if (m_idx == NW) begin
          m_idx   = 0;
          m_phase = 2;
        end
      end else if (xfer) begin
        m_v = 0;
      end
      if (m_phase == 3) m_done_cnt++;
    end
    @(negedge clk);
    if (pop) src_next = seq_data ? src_next + 1 : $urandom;
    if (done) dut_done_cnt++;
    check_eq("busy", busy, (m_phase == 1) || (m_phase == 2));
    check_eq("done", done, m_phase == 3);
    check_eq("frm_vld", frm_vld, m_v);
    check_eq("stall_cnt", stall_cnt, m_stall);
    if (m_v) begin
      check_eq("frm_data", frm_data, m_data);
      check_eq("frm_sof", frm_sof, m_sof);
      check_eq("frm_eol", frm_eol, m_eol);
    end
  endtask

  task automatic start_frame();
    seq_data = 1;
    src_next = 1;
    start = 1;
    step();
    start = 0;
  endtask

  // Step until the DUT pulses done; a blown budget counts as a failure.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    check_eq({tag, "_done_seen"}, done, 1'b1);
  endtask

  int base, cnt;

  initial begin
    rst = 1; start = 1; abort = 1; rd_vld = 1; frm_rdy = 1;
    seq_data = 1; src_next = 1;
    m_done_cnt = 0; dut_done_cnt = 0; xfer_cnt = 0;
    model_reset();
    @(negedge clk);
    step();
    step();
    check_eq("rst_frm_data", frm_data, 0);
    check_eq("rst_frm_sof", frm_sof, 0);
    check_eq("rst_frm_eol", frm_eol, 0);
    check_eq("rst_busy", busy, 0);
    rst = 0; start = 0; abort = 0;
    step();

    // Streaming: 8 words back to back.
    base = xfer_cnt;
    start_frame();
    wait_done("stream");
    check_eq("stream_words", xfer_cnt - base, NW);
    check_eq("stream_stall", stall_cnt, 0);
    step();

    // Backpressure while word 2 sits in the output register.
    base = xfer_cnt; cnt = 0;
    start_frame();
    for (int i = 0; i < 60 && !done; i++) begin
      frm_rdy = (m_v && m_data == 2 && cnt < 3) ? 1'b0 : 1'b1;
      if (!frm_rdy) cnt++;
      step();
    end
    frm_rdy = 1;
    check_eq("bp_done", done, 1'b1);
    check_eq("bp_hold_cycles", cnt, 3);
    check_eq("bp_words", xfer_cnt - base, NW);
    check_eq("bp_stall", stall_cnt, 0);
    step();

    // Underrun: FIFO empty for 5 cycles after word 3.
    cnt = 0;
    start_frame();
    for (int i = 0; i < 60 && !done; i++) begin
      rd_vld = (m_idx == 3 && cnt < 5) ? 1'b0 : 1'b1;
      if (!rd_vld) cnt++;
      step();
    end
    rd_vld = 1;
    check_eq("ur_done", done, 1'b1);
    check_eq("ur_stall", stall_cnt, 5);
    step();

    // Abort while word 5 is on the output, then a fresh frame.
    start_frame();
    for (int i = 0; i < 40 && !(m_v && m_data == 5); i++) step();
    check_eq("ab_word5", frm_data, 5);
    abort = 1;
    step();
    abort = 0;
    check_eq("ab_vld", frm_vld, 0);
    check_eq("ab_busy", busy, 0);
    check_eq("ab_done", done, 0);
    step(); step();
    start_frame();
    for (int i = 0; i < 10 && !m_v; i++) step();
    check_eq("ab_restart_sof", frm_sof, 1'b1);
    check_eq("ab_restart_data", frm_data, 1);
    wait_done("ab_restart");
    step();

    // Reset in FLUSH with the sink stalled; start while busy is ignored.
    start_frame();
    for (int i = 0; i < 40 && m_phase != 2; i++) begin
      start = 1;
      step();
    end
    start = 0;
    frm_rdy = 0;
    step();
    check_eq("fl_busy", busy, 1'b1);
    check_eq("fl_vld", frm_vld, 1'b1);
    rst = 1; start = 1;
    step();
    rst = 0; start = 0; frm_rdy = 1;
    check_eq("fl_rst_vld", frm_vld, 0);
    check_eq("fl_rst_busy", busy, 0);
    check_eq("fl_rst_done", done, 0);
    check_eq("fl_rst_data", frm_data, 0);
    step(); step(); step();

    // Randomized traffic with occasional abort and reset.
    seq_data = 0;
    src_next = $urandom;
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 599) == 0);
      abort   = ($urandom_range(0, 149) == 0);
      start   = ($urandom_range(0, 7) == 0);
      rd_vld  = ($urandom_range(0, 3) != 0);
      frm_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 0; abort = 0; start = 0;
    step();
    check_eq("done_count", dut_done_cnt, m_done_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
